updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
// PURPOSE
//  Parametrised up/down counter with synchronous load, clock-enable prescaler,
//  wrap or saturate boundary mode, boundary pulse and sticky over/underflow flags.
//  Next-generation general counter for the verification study designs.
//  Used as a timer, event counter or loop index by the FSM and stimulus blocks.
// PARAMETERS
//  WIDTH      4            counter width in bits (2..32)
//  MAX_VAL    2**WIDTH-1   upper bound of the count range; lower bound is 0
//  RESET_VAL  MAX_VAL      count value after reset; must be <= MAX_VAL
//  DIV        1            prescaler: count advances once per DIV enabled cycles (1..256)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous reset, active-high
//  en         in   1      count enable; feeds the prescaler
//  up         in   1      direction: 1 = increment, 0 = decrement
//  sat_mode   in   1      1 = saturate at the bounds, 0 = wrap at the bounds
//  load       in   1      synchronous load of load_val
//  load_val   in   WIDTH  load value; clamped to MAX_VAL
//  clr_flags  in   1      clears ovf_sticky and unf_sticky
//  count      out  WIDTH  current count (registered)
//  at_max     out  1      combinational: count == MAX_VAL
//  at_zero    out  1      combinational: count == 0
//  bnd_pulse  out  1      registered 1-cycle pulse after a tick that hit a bound
//  ovf_sticky out  1      set by an up-tick at MAX_VAL
//  unf_sticky out  1      set by a down-tick at 0
// BEHAVIOUR
//  Reset (reset=1 at posedge): count=RESET_VAL, prescaler=0, bnd_pulse=0, ovf/unf=0.
//  Reset has priority over all other inputs, including mid-prescale and mid-load.
//  Priority after reset: load > tick > hold.
//  - Prescaler: presc counts 0..DIV-1 on cycles with en=1 and holds when en=0.
//    tick = en && (presc == DIV-1); presc returns to 0 on tick.
//    DIV=1 gives tick = en.
//  - load=1: count = min(load_val, MAX_VAL); presc=0; no tick that cycle.
//    Flags are unaffected and bnd_pulse=0.
//  - tick, up=1:
//    count<MAX_VAL -> count+1.
//    count==MAX_VAL -> wrap to 0 (sat_mode=0) or hold (sat_mode=1); set ovf_sticky.
//  - tick, up=0:
//    count>0 -> count-1.
//    count==0 -> wrap to MAX_VAL (sat_mode=0) or hold (sat_mode=1); set unf_sticky.
//  - bnd_pulse=1 for exactly the cycle after any boundary tick, in either mode; else 0.
//  - Arithmetic is modulo the bounds, never 2**WIDTH.
//    Intermediate compares are WIDTH bits wide with no carry-out.
//  - clr_flags=1 clears both sticky flags next cycle.
//    A boundary tick in the same cycle wins: the flag stays 1.
//  - Changing up or sat_mode mid-prescale takes effect on the next tick; presc is not reset.
//  - count latency: load or tick is visible on count 1 cycle after the sampling edge.
//  - at_max and at_zero follow count with 0 latency.
// TESTING (WIDTH=4, MAX_VAL=15, RESET_VAL=15 unless noted)
//  1 reset=1 for 1 cycle -> count=15, flags=0; then en=1, up=0 for 16 cycles
//    -> count runs 14..0, then 15; bnd_pulse=1 once; unf_sticky=1.
//  2 sat_mode=1, up=1, load 13, en=1 for 4 cycles
//    -> count 14, 15, 15, 15; ovf_sticky=1; bnd_pulse high on each hold.
//  3 MAX_VAL=9: load_val=12 -> count=9;
//    up-tick -> count=0 (wrap at 9, not 15); ovf_sticky=1.
//  4 DIV=3, en=1 continuously, up=1 from 0 -> count steps every 3rd cycle: 1, 2, 3.
//    en=0 for 5 cycles mid-period -> count and presc frozen.
//  5 clr_flags=1 in the same cycle as a boundary tick -> flag stays 1;
//    clr_flags alone on the next cycle -> flag 0.
//  6 load=1 with tick pending -> load_val wins, presc=0;
//    reset=1 during a load cycle -> count=RESET_VAL.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: load > prescaled tick > hold, wrap/saturate bounds, sticky flags.
// count, bnd_pulse and flags update one cycle after the sampling edge; at_max/at_zero follow count combinationally.
module updown_counter_param #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RESET_VAL = MAX_VAL,
    parameter int unsigned     DIV       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             bnd_pulse,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_W = RESET_VAL[WIDTH-1:0];
    localparam int unsigned      PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             bnd_q, bnd_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic tick;
    logic hit_max;
    logic hit_zero;
    logic ovf_set;
    logic unf_set;

    assign hit_max  = (count_q == MAX_W);
    assign hit_zero = (count_q == '0);
    // With DIV=1 the prescaler is pinned at 0 so tick reduces to en.
    assign tick     = en && (presc_q == PRESC_LAST);

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        bnd_d   = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
            presc_d = '0;
        end else begin
            if (en) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                if (up) begin
                    if (hit_max) begin
                        ovf_set = 1'b1;
                        bnd_d   = 1'b1;
                        if (!sat_mode) begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (hit_zero) begin
                        unf_set = 1'b1;
                        bnd_d   = 1'b1;
                        if (!sat_mode) begin
                            count_d = MAX_W;
                        end
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
        end

        // A boundary tick beats a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~clr_flags);
        unf_d = unf_set | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_W;
            presc_q <= '0;
            bnd_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            bnd_q   <= bnd_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= MAX_W);
        end
    end

    assign count      = count_q;
    assign at_max     = hit_max;
    assign at_zero    = hit_zero;
    assign bnd_pulse  = bnd_q;
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    logic       clk;
    logic       reset, en, up, sat_mode, load, clr_flags;
    logic [3:0] load_val;

    logic [3:0] cnt_a, cnt_m, cnt_d;
    logic       max_a, zero_a, bnd_a, ovf_a, unf_a;
    logic       max_m, zero_m, bnd_m, ovf_m, unf_m;
    logic       max_d, zero_d, bnd_d, ovf_d, unf_d;

    int nvec = 0;
    int nerr = 0;

    updown_counter_param #(.WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_flags(clr_flags),
        .count(cnt_a), .at_max(max_a), .at_zero(zero_a), .bnd_pulse(bnd_a),
        .ovf_sticky(ovf_a), .unf_sticky(unf_a)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9)) dut_m (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_flags(clr_flags),
        .count(cnt_m), .at_max(max_m), .at_zero(zero_m), .bnd_pulse(bnd_m),
        .ovf_sticky(ovf_m), .unf_sticky(unf_m)
    );

    updown_counter_param #(.WIDTH(4), .DIV(3)) dut_d (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_flags(clr_flags),
        .count(cnt_d), .at_max(max_d), .at_zero(zero_d), .bnd_pulse(bnd_d),
        .ovf_sticky(ovf_d), .unf_sticky(unf_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, up, sat, ld;
        logic [3:0] lv;
        logic       clr;
        logic [3:0] cnt;
        logic       bnd, ovf, unf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic e, input logic u, input logic s,
                                input logic l, input int lv, input logic c,
                                input int cnt, input logic b, input logic o, input logic un);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.sat = s; v.ld = l; v.lv = 4'(lv); v.clr = c;
        v.cnt = 4'(cnt); v.bnd = b; v.ovf = o; v.unf = un;
        return v;
    endfunction

    task automatic drive(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input int lv, input logic c);
        reset = r; en = e; up = u; sat_mode = s; load = l; load_val = 4'(lv); clr_flags = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    int exp_div[8] = '{0, 0, 1, 1, 1, 2, 2, 2};

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset, then count down through zero with wrap.
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0));
        for (int k = 1; k <= 15; k++) vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 15 - k, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 15, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 1));
        // Saturating up from 13.
        vq.push_back(mk(0, 0, 1, 1, 1, 13, 0, 13, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 14, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 15, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 15, 1, 1, 1));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 15, 1, 1, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 15, 0, 1, 1));
        // Clear racing a boundary tick, then clear alone.
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 15, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 15, 0, 0, 0));
        // Saturating underflow.
        vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
        // Load beats tick; reset beats load.
        vq.push_back(mk(0, 1, 1, 0, 1, 5, 0, 5, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 6, 0, 0, 1));
        vq.push_back(mk(1, 1, 1, 0, 1, 7, 0, 15, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0));

        foreach (vq[i]) begin
            logic [8:0] act, exp;
            drive(vq[i].rst, vq[i].en, vq[i].up, vq[i].sat, vq[i].ld, int'(vq[i].lv), vq[i].clr);
            step();
            act = {cnt_a, max_a, zero_a, bnd_a, ovf_a, unf_a};
            exp = {vq[i].cnt, vq[i].cnt == 4'd15, vq[i].cnt == 4'd0, vq[i].bnd, vq[i].ovf, vq[i].unf};
            chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
        end

        // MAX_VAL=9: clamp on load and wrap at 9.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        chk("m_reset", 32'(cnt_m), 9);
        drive(0, 0, 0, 0, 1, 12, 0); step();
        chk("m_clamp", 32'(cnt_m), 9);
        chk("m_atmax", 32'(max_m), 1);
        drive(0, 1, 1, 0, 0, 0, 0); step();
        chk("m_wrap", 32'(cnt_m), 0);
        chk("m_ovf", 32'(ovf_m), 1);
        chk("m_bnd", 32'(bnd_m), 1);
        drive(0, 1, 0, 0, 0, 0, 0); step();
        chk("m_unwrap", 32'(cnt_m), 9);
        chk("m_unf", 32'(unf_m), 1);
        drive(0, 0, 0, 0, 1, 8, 0); step();
        chk("m_load8", 32'(cnt_m), 8);
        drive(0, 1, 1, 0, 0, 0, 0); step();
        chk("m_to_max", 32'(cnt_m), 9);
        chk("m_nobnd", 32'(bnd_m), 0);

        // DIV=3 prescaler.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0, 0); step();
        chk("d_load0", 32'(cnt_d), 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("d_run%0d", c), 32'(cnt_d), 32'(exp_div[c]));
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("d_frozen%0d", c), 32'(cnt_d), 2);
        end
        drive(0, 1, 1, 0, 0, 0, 0); step();
        chk("d_resume", 32'(cnt_d), 3);
        step();
        drive(0, 1, 0, 0, 0, 0, 0); step();
        chk("d_dir_hold", 32'(cnt_d), 3);
        step();
        chk("d_dirchg", 32'(cnt_d), 2);
        step(); step();
        drive(0, 1, 0, 0, 1, 5, 0); step();
        chk("d_load_pending", 32'(cnt_d), 5);
        drive(0, 1, 0, 0, 0, 0, 0); step();
        chk("d_presc_clr0", 32'(cnt_d), 5);
        step();
        chk("d_presc_clr1", 32'(cnt_d), 5);
        step();
        chk("d_presc_clr2", 32'(cnt_d), 4);
        drive(1, 1, 1, 0, 1, 5, 0); step();
        chk("d_rst_load", 32'(cnt_d), 15);
        drive(0, 0, 0, 0, 0, 0, 0); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
